audio_mixer_tdm: RTL



---
 rtl/audio_mixer_tdm.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/audio_mixer_tdm.sv
// audio_mixer_tdm: time-multiplexed N-channel audio mixer.
// Each offset-binary input code is re-centred, scaled by a per-channel gain
// (or muted), summed one channel per cycle through a single MAC, then shifted
// and saturated to a signed output sample once per accepted sample strobe.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   ce_sample    one-cycle sample strobe (accepted only when idle)
//   in_data      CHANNELS packed input codes, channel k at [k*IN_W +: IN_W]
//   cfg_we       gain/mute write enable (cfg_ch, cfg_gain, cfg_mute)
//   clear_flags  clears sticky clip/overrun (a same-cycle set wins)
//   out_sample   signed mixed sample, held between updates
//   out_valid    one-cycle pulse when out_sample updates
//   busy         high while a sample is being mixed
//   clip         sticky: an output saturated
//   overrun      sticky: a ce_sample arrived while busy and was dropped
module audio_mixer_tdm #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned IN_W         = 8,
    parameter int unsigned GAIN_W       = 4,
    parameter int unsigned OUT_W        = 16,
    parameter int unsigned DEFAULT_GAIN = 2 ** (GAIN_W - 1)
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              ce_sample,
    input  logic [CHANNELS*IN_W-1:0]                          in_data,
    input  logic                                              cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [GAIN_W-1:0]                                 cfg_gain,
    input  logic                                              cfg_mute,
    input  logic                                              clear_flags,
    output logic [OUT_W-1:0]                                  out_sample,
    output logic                                              out_valid,
    output logic                                              busy,
    output logic                                              clip,
    output logic                                              overrun
);

    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PROD_W = IN_W + GAIN_W + 1;
    localparam int unsigned ACC_W  = PROD_W + $clog2(CHANNELS);
    localparam int unsigned SHIFT  = OUT_W + 1 - IN_W - GAIN_W;
    localparam int unsigned SH_W   = ACC_W + SHIFT;

    // Reject parameter sets the datapath cannot represent.
    if (OUT_W + 1 < IN_W + GAIN_W) begin : g_bad_out_w
        $error("audio_mixer_tdm: OUT_W must be >= IN_W+GAIN_W-1");
    end
    if (CHANNELS < 2) begin : g_bad_channels
        $error("audio_mixer_tdm: CHANNELS must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state, state_d;

    // Live configuration and per-sample shadow copies.
    logic [GAIN_W-1:0] gain_live [CHANNELS];
    logic              mute_live [CHANNELS];
    logic [GAIN_W-1:0] gain_shd  [CHANNELS];
    logic              mute_shd  [CHANNELS];
    logic [IN_W-1:0]   in_shd    [CHANNELS];

    logic signed [ACC_W-1:0]  acc;
    logic [CH_W-1:0]          cnt;

    logic                     snap;
    logic                     acc_en;
    logic                     out_load;
    logic                     busy_d;
    logic                     clip_d;
    logic                     ovr_d;
    logic                     cfg_ok;

    logic signed [IN_W-1:0]   s_cur;
    logic signed [PROD_W-1:0] term;
    logic signed [SH_W-1:0]   shifted;
    logic [SH_W-OUT_W:0]      upper;
    logic                     sat;
    logic [OUT_W-1:0]         sat_value;

    assign cfg_ok = cfg_we && (32'(cfg_ch) < CHANNELS);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (ce_sample) state_d = ACCUM;
            ACCUM:   if (cnt == CH_W'(CHANNELS - 1)) state_d = OUTPUT;
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-derived controls and next values of the registered outputs.
    always_comb begin
        snap     = (state == IDLE) && ce_sample;
        acc_en   = (state == ACCUM);
        out_load = (state == OUTPUT);
        busy_d   = (state_d != IDLE);
        // Sticky flags: a set in the same cycle as clear_flags wins.
        clip_d   = (out_load && sat) || (clip && !clear_flags);
        ovr_d    = (ce_sample && (state != IDLE)) || (overrun && !clear_flags);
    end

    // MAC term for the current channel and the saturating output stage.
    always_comb begin
        // Flipping the MSB of an offset-binary code gives code - 2^(IN_W-1).
        s_cur   = $signed({~in_shd[cnt][IN_W-1], in_shd[cnt][IN_W-2:0]});
        term    = mute_shd[cnt] ? '0
                : PROD_W'(s_cur) * PROD_W'($signed({1'b0, gain_shd[cnt]}));
        shifted = SH_W'(acc) <<< SHIFT;
        // Result fits OUT_W only if every bit above the output sign matches it.
        upper   = shifted[SH_W-1:OUT_W-1];
        sat     = !((&upper) || !(|upper));
        if (!sat) begin
            sat_value = shifted[OUT_W-1:0];
        end else if (shifted[SH_W-1]) begin
            sat_value = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            sat_value = {1'b0, {(OUT_W - 1){1'b1}}};
        end
    end

    // Configuration, snapshot, accumulator and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                gain_live[k] <= GAIN_W'(DEFAULT_GAIN);
                mute_live[k] <= 1'b0;
                gain_shd[k]  <= GAIN_W'(DEFAULT_GAIN);
                mute_shd[k]  <= 1'b0;
                in_shd[k]    <= '0;
            end
            acc        <= '0;
            cnt        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (cfg_ok) begin
                gain_live[cfg_ch] <= cfg_gain;
                mute_live[cfg_ch] <= cfg_mute;
            end
            // Shadows take the pre-write live values when cfg_we coincides.
            if (snap) begin
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    gain_shd[k] <= gain_live[k];
                    mute_shd[k] <= mute_live[k];
                    in_shd[k]   <= in_data[k*IN_W +: IN_W];
                end
                acc <= '0;
                cnt <= '0;
            end else if (acc_en) begin
                acc <= acc + ACC_W'(term);
                cnt <= cnt + CH_W'(1);
            end
            if (out_load) begin
                out_sample <= sat_value;
            end
            out_valid <= out_load;
            busy      <= busy_d;
            clip      <= clip_d;
            overrun   <= ovr_d;
        end
    end

endmodule
